ccip_mmio_csr: RTL and testbench

- MMIO control/status register block inside the user AFU.
- Consumes the registered CCI-P Rx port produced by the interface register stage.
- Decodes host MMIO reads/writes on channel c0, holds the AFU device-feature header, AFU ID, scratch and counter registers.
- Returns MMIO read responses on Tx channel c2; c0/c1 Tx are owned by other AFU logic.

---
 rtl/ccip_mmio_csr.sv | 142 ++++++++++++++
 tb/tb_ccip_mmio_csr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ccip_mmio_csr.sv
// rtl/ccip_mmio_csr.sv - AFU MMIO CSR block: DFH, AFU ID, scratch and counters on CCI-P c0/c2
// Read responses leave on c2 exactly two cycles after the request; writes land on the request edge.
module ccip_mmio_csr #(
   parameter logic [63:0] AFU_ID_L    = 64'h0,
   parameter logic [63:0] AFU_ID_H    = 64'h0,
   parameter logic [3:0]  DFH_REV     = 4'h0,
   parameter int          NUM_SCRATCH = 4
) (
   input  logic        Clk_400,
   input  logic        SoftReset,
   input  logic        cp2af_sRxPort_c0_mmioRdValid,
   input  logic        cp2af_sRxPort_c0_mmioWrValid,
   input  logic [15:0] cp2af_sRxPort_c0_hdr_address,
   input  logic [1:0]  cp2af_sRxPort_c0_hdr_length,
   input  logic [8:0]  cp2af_sRxPort_c0_hdr_tid,
   input  logic [63:0] cp2af_sRxPort_c0_data,
   output logic        af2cp_sTxC2_mmioRdValid,
   output logic [8:0]  af2cp_sTxC2_hdr_tid,
   output logic [63:0] af2cp_sTxC2_data
);

   localparam logic [14:0] IDX_DFH      = 15'd0;
   localparam logic [14:0] IDX_AFU_ID_L = 15'd1;
   localparam logic [14:0] IDX_AFU_ID_H = 15'd2;
   localparam logic [14:0] IDX_CYCLE    = 15'd9;
   localparam logic [14:0] IDX_WR_CNT   = 15'd10;
   localparam int          IDX_SCRATCH0 = 5;

   localparam logic [1:0]  LEN_4B = 2'b00;
   localparam logic [1:0]  LEN_8B = 2'b01;

   localparam logic [63:0] DFH_VALUE = {4'h1, 19'h0, 1'b1, 24'h0, DFH_REV, 12'h000};

   logic [14:0] rx_idx;
   logic        rx_hi;

   logic [63:0] scratch [NUM_SCRATCH];
   logic [63:0] cycle_cnt;
   logic [31:0] wr_cnt;

   logic        s1_valid;
   logic [8:0]  s1_tid;
   logic [14:0] s1_idx;
   logic        s1_hi;
   logic [1:0]  s1_len;
   logic [63:0] s1_cycle;

   logic [63:0] reg_val;
   logic [63:0] rsp_data;

   assign rx_idx = cp2af_sRxPort_c0_hdr_address[15:1];
   assign rx_hi  = cp2af_sRxPort_c0_hdr_address[0];

   // Register state and write path; RO and unmapped offsets only bump WR_CNT.
   always_ff @(posedge Clk_400) begin
      if (SoftReset) begin
         cycle_cnt <= '0;
         wr_cnt    <= '0;
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            scratch[i] <= '0;
         end
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (cp2af_sRxPort_c0_mmioWrValid) begin
            if (wr_cnt != 32'hFFFF_FFFF) begin
               wr_cnt <= wr_cnt + 32'd1;
            end
            for (int i = 0; i < NUM_SCRATCH; i++) begin
               if (rx_idx == 15'(IDX_SCRATCH0 + i)) begin
                  if (cp2af_sRxPort_c0_hdr_length == LEN_8B) begin
                     scratch[i] <= cp2af_sRxPort_c0_data;
                  end else if (cp2af_sRxPort_c0_hdr_length == LEN_4B) begin
                     if (rx_hi) begin
                        scratch[i][63:32] <= cp2af_sRxPort_c0_data[31:0];
                     end else begin
                        scratch[i][31:0] <= cp2af_sRxPort_c0_data[31:0];
                     end
                  end
               end
            end
         end
      end
   end

   // Stage 1 snapshots the cycle counter so the read reports the request-cycle value.
   always_ff @(posedge Clk_400) begin
      if (SoftReset) begin
         s1_valid <= 1'b0;
         s1_tid   <= '0;
         s1_idx   <= '0;
         s1_hi    <= 1'b0;
         s1_len   <= '0;
         s1_cycle <= '0;
      end else begin
         s1_valid <= cp2af_sRxPort_c0_mmioRdValid;
         s1_tid   <= cp2af_sRxPort_c0_hdr_tid;
         s1_idx   <= rx_idx;
         s1_hi    <= rx_hi;
         s1_len   <= cp2af_sRxPort_c0_hdr_length;
         s1_cycle <= cycle_cnt;
      end
   end

   always_comb begin
      reg_val = '0;
      case (s1_idx)
         IDX_DFH:      reg_val = DFH_VALUE;
         IDX_AFU_ID_L: reg_val = AFU_ID_L;
         IDX_AFU_ID_H: reg_val = AFU_ID_H;
         IDX_CYCLE:    reg_val = s1_cycle;
         IDX_WR_CNT:   reg_val = {32'h0, wr_cnt};
         default:      reg_val = '0;
      endcase
      for (int i = 0; i < NUM_SCRATCH; i++) begin
         if (s1_idx == 15'(IDX_SCRATCH0 + i)) begin
            reg_val = scratch[i];
         end
      end

      rsp_data = '0;
      if (s1_valid) begin
         case (s1_len)
            LEN_8B:  rsp_data = reg_val;
            LEN_4B:  rsp_data = {32'h0, s1_hi ? reg_val[63:32] : reg_val[31:0]};
            default: rsp_data = '0;
         endcase
      end
   end

   always_ff @(posedge Clk_400) begin
      if (SoftReset) begin
         af2cp_sTxC2_mmioRdValid <= 1'b0;
         af2cp_sTxC2_hdr_tid     <= '0;
         af2cp_sTxC2_data        <= '0;
      end else begin
         af2cp_sTxC2_mmioRdValid <= s1_valid;
         af2cp_sTxC2_hdr_tid     <= s1_valid ? s1_tid : 9'h0;
         af2cp_sTxC2_data        <= rsp_data;
      end
   end

endmodule

// File: tb/tb_ccip_mmio_csr.sv
// tb/tb_ccip_mmio_csr.sv - directed checks of the MMIO CSR block's read/write map and pipeline
module tb_ccip_mmio_csr;

   localparam logic [63:0] ID_L = 64'hA5A5_0000_1234_5678;
   localparam logic [63:0] ID_H = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] DFH  = 64'h1000_0100_0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_valid = 1'b0;
   logic        wr_valid = 1'b0;
   logic [15:0] addr = '0;
   logic [1:0]  len = '0;
   logic [8:0]  tid = '0;
   logic [63:0] wdata = '0;
   logic        rsp_valid;
   logic [8:0]  rsp_tid;
   logic [63:0] rsp_data;

   int compared = 0;
   int mismatched = 0;

   ccip_mmio_csr #(
      .AFU_ID_L(ID_L), .AFU_ID_H(ID_H), .DFH_REV(4'h0), .NUM_SCRATCH(4)
   ) dut (
      .Clk_400(clk),
      .SoftReset(rst),
      .cp2af_sRxPort_c0_mmioRdValid(rd_valid),
      .cp2af_sRxPort_c0_mmioWrValid(wr_valid),
      .cp2af_sRxPort_c0_hdr_address(addr),
      .cp2af_sRxPort_c0_hdr_length(len),
      .cp2af_sRxPort_c0_hdr_tid(tid),
      .cp2af_sRxPort_c0_data(wdata),
      .af2cp_sTxC2_mmioRdValid(rsp_valid),
      .af2cp_sTxC2_hdr_tid(rsp_tid),
      .af2cp_sTxC2_data(rsp_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [1:0]  len;
      logic [8:0]  tid;
      logic [63:0] exp;
   } rd_vec_t;

   rd_vec_t vecs [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one cycle of c0 inputs; returns 1 ns after the sampling edge.
   task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [1:0] l,
                        input logic [8:0] t, input logic [63:0] d);
      rd_valid = r;
      wr_valid = w;
      addr     = a;
      len      = l;
      tid      = t;
      wdata    = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 16'h0, 2'b00, 9'h0, 64'h0);
   endtask

   task automatic check_rsp(input string name, input logic [8:0] etid, input logic [63:0] edata);
      @(negedge clk);
      check({name, "_valid"}, {63'h0, rsp_valid}, 64'h1);
      check({name, "_tid"}, {55'h0, rsp_tid}, {55'h0, etid});
      check({name, "_data"}, rsp_data, edata);
   endtask

   task automatic check_quiet(input string name);
      @(negedge clk);
      check({name, "_valid"}, {63'h0, rsp_valid}, 64'h0);
      check({name, "_data"}, rsp_data, 64'h0);
   endtask

   // One read in isolation: request, one idle cycle, response, then quiet.
   task automatic read_check(input string name, input logic [15:0] a, input logic [1:0] l,
                             input logic [8:0] t, input logic [63:0] e);
      drive(1'b1, 1'b0, a, l, t, 64'h0);
      idle();
      check_rsp(name, t, e);
      idle();
      check_quiet({name, "_after"});
   endtask

   task automatic write(input logic [15:0] a, input logic [1:0] l, input logic [63:0] d);
      drive(1'b0, 1'b1, a, l, 9'h0, d);
   endtask

   initial begin
      bit seen;

      vecs[0]  = '{16'd0,      2'b01, 9'h005, DFH};
      vecs[1]  = '{16'd2,      2'b00, 9'h006, 64'h0000_0000_1234_5678};
      vecs[2]  = '{16'd3,      2'b00, 9'h007, 64'h0000_0000_A5A5_0000};
      vecs[3]  = '{16'd2,      2'b01, 9'h008, ID_L};
      vecs[4]  = '{16'd4,      2'b01, 9'h009, ID_H};
      vecs[5]  = '{16'd5,      2'b00, 9'h00A, 64'h0000_0000_0123_4567};
      vecs[6]  = '{16'd6,      2'b01, 9'h00B, 64'h0};
      vecs[7]  = '{16'd10,     2'b01, 9'h1FF, 64'h0};
      vecs[8]  = '{16'd0,      2'b10, 9'h00C, 64'h0};
      vecs[9]  = '{16'd20,     2'b01, 9'h00D, 64'h0};
      vecs[10] = '{16'hFFFE,   2'b01, 9'h00E, 64'h0};

      repeat (3) idle();
      @(negedge clk);
      check("reset_valid", {63'h0, rsp_valid}, 64'h0);
      check("reset_tid", {55'h0, rsp_tid}, 64'h0);
      check("reset_data", rsp_data, 64'h0);
      rst = 1'b0;
      idle();

      for (int i = 0; i < 11; i++) begin
         read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].len, vecs[i].tid, vecs[i].exp);
      end

      // Scratch writes, including a read the cycle right after a write to the same register.
      write(16'd10, 2'b01, 64'hDEAD_BEEF_CAFE_F00D);
      write(16'd11, 2'b00, 64'hFFFF_FFFF_1111_2222);
      read_check("scratch0_merge", 16'd10, 2'b01, 9'h021, 64'h1111_2222_CAFE_F00D);
      write(16'd16, 2'b01, 64'h0BAD_F00D_5555_AAAA);
      read_check("scratch3_hi", 16'd17, 2'b00, 9'h022, 64'h0000_0000_0BAD_F00D);
      read_check("scratch3_lo", 16'd16, 2'b00, 9'h023, 64'h0000_0000_5555_AAAA);
      write(16'd10, 2'b10, 64'h0);
      read_check("scratch0_64b_wr", 16'd10, 2'b01, 9'h024, 64'h1111_2222_CAFE_F00D);
      read_check("wr_cnt_4", 16'd20, 2'b01, 9'h025, 64'd4);

      // Back-to-back reads: responses must stream out in order with no gaps.
      drive(1'b1, 1'b0, 16'd0,  2'b01, 9'h001, 64'h0);
      drive(1'b1, 1'b0, 16'd2,  2'b01, 9'h002, 64'h0);
      check_rsp("b2b_1", 9'h001, DFH);
      drive(1'b1, 1'b0, 16'd4,  2'b01, 9'h003, 64'h0);
      check_rsp("b2b_2", 9'h002, ID_L);
      drive(1'b1, 1'b0, 16'd62, 2'b01, 9'h004, 64'h0);
      check_rsp("b2b_3", 9'h003, ID_H);
      idle();
      check_rsp("b2b_4", 9'h004, 64'h0);
      idle();
      check_quiet("b2b_end");

      // Simultaneous read and write share the header: both must take effect.
      drive(1'b1, 1'b1, 16'd12, 2'b01, 9'h033, 64'h0123_0000_4567_89AB);
      idle();
      @(negedge clk);
      check("rdwr_valid", {63'h0, rsp_valid}, 64'h1);
      check("rdwr_tid", {55'h0, rsp_tid}, 64'h033);
      idle();
      read_check("rdwr_scratch1", 16'd12, 2'b01, 9'h034, 64'h0123_0000_4567_89AB);
      read_check("wr_cnt_5", 16'd20, 2'b01, 9'h035, 64'd5);

      // Cycle counter after reset release, then WR_CNT from unmapped writes.
      rst = 1'b1;
      idle();
      idle();
      rst = 1'b0;
      repeat (99) idle();
      drive(1'b1, 1'b0, 16'd18, 2'b01, 9'h040, 64'h0);
      idle();
      check_rsp("cycle_99", 9'h040, 64'd99);
      idle();
      for (int i = 0; i < 3; i++) begin
         write(16'd60, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
      end
      read_check("wr_cnt_3", 16'd20, 2'b01, 9'h041, 64'd3);
      read_check("scratch0_after_rst", 16'd10, 2'b01, 9'h042, 64'h0);
      read_check("scratch1_after_rst", 16'd12, 2'b01, 9'h043, 64'h0);

      // Reset in the cycle after a read: that response must never appear.
      drive(1'b1, 1'b0, 16'd0, 2'b01, 9'h077, 64'h0);
      rst = 1'b1;
      idle();
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("rst_drop_valid", {63'h0, seen}, 64'h0);
      idle();
      read_check("rd_64b_after_rst", 16'd0, 2'b10, 9'h078, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
